// File: rtl/instr_encoder.sv
// Instruction encoder: packs opcode/flag/field tuples into 9-bit words and writes them
// sequentially into instruction memory. Define ENCODER_CHECK_EN to reject register-form tuples with in_field[4] set.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_flag,
  input  logic [4:0]        in_field,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [3:0]        OP_STOP  = 4'hF;

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [8:0]        wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic       hs, is_stop, is_reg, illegal, do_write, last_addr, restart;
  logic [8:0] enc_word;

  assign hs        = in_valid && (state_q == RUN);
  assign is_stop   = (in_op == OP_STOP);
  assign is_reg    = (in_op == 4'h4) || (in_op == 4'hD) || (in_op == 4'hE) ||
                     (((in_op == 4'hB) || (in_op == 4'hC)) && in_flag);
  assign last_addr = (next_addr_q == ADDR_MAX);
  assign restart   = start && (state_q != RUN);
  assign do_write  = hs && !illegal;

`ifdef ENCODER_CHECK_EN
  logic err_q, err_d;

  // Illegal tuples are still consumed so the source never stalls on them.
  assign illegal = is_reg && in_field[4];

  always_comb begin
    err_d = err_q;
    if (restart)
      err_d = 1'b0;
    else if (hs && illegal)
      err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    enc_word = {in_op, in_field};
    if (is_stop)
      enc_word = {OP_STOP, 5'b0};
    else if (is_reg)
      enc_word = {in_op, in_flag, in_field[3:0]};
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (do_write && (is_stop || last_addr)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == RUN);
    done     = (state_q == DONE);
  end

  // Write pipeline and session counters
  always_comb begin
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    if (restart) begin
      wr_addr_d   = '0;
      next_addr_d = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
    end else if (do_write) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = next_addr_q;
      wr_data_d   = enc_word;
      next_addr_d = next_addr_q + ADDR_ONE;
      count_d     = count_q + CNT_ONE;
      if (!is_stop && last_addr)
        overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      next_addr_q <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
